lsc_i2cs_reg_arb: RTL

LSC_I2CS_REG_ARB -- requirements
Module: lsc_i2cs_reg_arb

---
 rtl/lsc_i2cs_pkg.sv | 27 ++
 rtl/lsc_i2cs_reg_arb.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/lsc_i2cs_pkg.sv
// Shared constants for the I2C-slave / local-core register bank arbiter:
// device select default, register map addresses and local FSM encoding.
package lsc_i2cs_pkg;

    localparam logic [3:0] DEV_SEL_DEF = 4'hE;

    localparam logic [7:0] ADDR_CFG0  = 8'h00;
    localparam logic [7:0] ADDR_CFG1  = 8'h01;
    localparam logic [7:0] ADDR_CFG2  = 8'h02;
    localparam logic [7:0] ADDR_CFG3  = 8'h03;
    localparam logic [7:0] ADDR_STAT0 = 8'h10;
    localparam logic [7:0] ADDR_STAT1 = 8'h11;
    localparam logic [7:0] ADDR_FLAGS = 8'h20;
    localparam logic [7:0] ADDR_MASK  = 8'h21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOC  = 2'd1,
        ST_RESP = 2'd2
    } loc_state_t;

    // Config registers occupy 0x00-0x03.
    function automatic logic is_cfg(input logic [7:0] addr);
        return (addr[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lsc_i2cs_reg_arb.sv
// Register bank shared between an I2C slave and a local core.
// I2C strobes always win their cycle; a pending local access simply waits
// in LOC until a strobe-free cycle, so the two sides never write together.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no local access in progress; i_loc_req starts one
// LOC   | local access performed this cycle unless an I2C strobe owns it
// RESP  | o_loc_valid high, o_loc_rdata holds the read value
module lsc_i2cs_reg_arb
    import lsc_i2cs_pkg::*;
#(
    parameter logic [3:0] DEV_SEL = DEV_SEL_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] i_dev_addr,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_wdata,
    input  logic       i_wr,
    input  logic       i_rd,
    output logic [7:0] o_rdata,
    input  logic       i_loc_req,
    input  logic       i_loc_we,
    input  logic [7:0] i_loc_addr,
    input  logic [7:0] i_loc_wdata,
    output logic       o_loc_gnt,
    output logic       o_loc_valid,
    output logic [7:0] o_loc_rdata,
    input  logic [7:0] i_event,
    output logic [7:0] o_config_00,
    output logic [7:0] o_config_01,
    output logic [7:0] o_config_02,
    output logic [7:0] o_config_03,
    output logic       o_irq
);

    loc_state_t state, state_nxt;

    logic [7:0] cfg [4];
    logic [7:0] status_00, status_01, shadow_01;
    logic [7:0] flags, mask;
    logic [7:0] rdata_q, loc_rdata_q;
    logic       irq_q;

    logic       dev_hit, i2c_wr, i2c_rd, i2c_act;
    logic       loc_do, loc_wr;
    logic [7:0] i2c_rd_mux, loc_rd_mux, flag_clr;

    assign dev_hit = (i_dev_addr == DEV_SEL);
    assign i2c_wr  = i_wr & dev_hit;
    assign i2c_rd  = i_rd & dev_hit;
    assign i2c_act = i2c_wr | i2c_rd;
    assign loc_wr  = loc_do & i_loc_we;

    assign flag_clr = (i2c_wr && (i_reg_addr == ADDR_FLAGS)) ? i_wdata : 8'h00;

    // Local FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Local FSM next state; the access happens in LOC only in a strobe-free cycle.
    always_comb begin
        state_nxt = state;
        loc_do    = 1'b0;
        case (state)
            ST_IDLE: if (i_loc_req) state_nxt = ST_LOC;
            ST_LOC: begin
                if (!i2c_act) begin
                    loc_do    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // I2C read view: status_01 is only visible through the shadow copy.
    always_comb begin
        i2c_rd_mux = 8'h00;
        if (is_cfg(i_reg_addr))              i2c_rd_mux = cfg[i_reg_addr[1:0]];
        else if (i_reg_addr == ADDR_STAT0)   i2c_rd_mux = status_00;
        else if (i_reg_addr == ADDR_STAT1)   i2c_rd_mux = shadow_01;
        else if (i_reg_addr == ADDR_FLAGS)   i2c_rd_mux = flags;
        else if (i_reg_addr == ADDR_MASK)    i2c_rd_mux = mask;
    end

    // Local read view: live registers.
    always_comb begin
        loc_rd_mux = 8'h00;
        if (is_cfg(i_loc_addr))              loc_rd_mux = cfg[i_loc_addr[1:0]];
        else if (i_loc_addr == ADDR_STAT0)   loc_rd_mux = status_00;
        else if (i_loc_addr == ADDR_STAT1)   loc_rd_mux = status_01;
        else if (i_loc_addr == ADDR_FLAGS)   loc_rd_mux = flags;
        else if (i_loc_addr == ADDR_MASK)    loc_rd_mux = mask;
    end

    // Register bank, flags, shadow and registered read data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) cfg[i] <= 8'h00;
            status_00   <= 8'h00;
            status_01   <= 8'h00;
            shadow_01   <= 8'h00;
            flags       <= 8'h00;
            mask        <= 8'h00;
            rdata_q     <= 8'h00;
            loc_rdata_q <= 8'h00;
            irq_q       <= 1'b0;
        end else begin
            if (i2c_wr) begin
                if (is_cfg(i_reg_addr))            cfg[i_reg_addr[1:0]] <= i_wdata;
                else if (i_reg_addr == ADDR_MASK)  mask <= i_wdata;
            end
            if (loc_wr) begin
                if (is_cfg(i_loc_addr))            cfg[i_loc_addr[1:0]] <= i_loc_wdata;
                else if (i_loc_addr == ADDR_STAT0) status_00 <= i_loc_wdata;
                else if (i_loc_addr == ADDR_STAT1) status_01 <= i_loc_wdata;
                else if (i_loc_addr == ADDR_MASK)  mask <= i_loc_wdata;
            end
            flags <= (flags & ~flag_clr) | i_event;
            if (i2c_rd) begin
                rdata_q <= i2c_rd_mux;
                if (i_reg_addr == ADDR_STAT0) shadow_01 <= status_01;
            end
            if (loc_do) loc_rdata_q <= i_loc_we ? 8'h00 : loc_rd_mux;
            irq_q <= |(flags & mask);
        end
    end

    assign o_loc_gnt   = loc_do;
    assign o_loc_valid = (state == ST_RESP);
    assign o_loc_rdata = loc_rdata_q;
    assign o_rdata     = rdata_q;
    assign o_irq       = irq_q;
    assign o_config_00 = cfg[0];
    assign o_config_01 = cfg[1];
    assign o_config_02 = cfg[2];
    assign o_config_03 = cfg[3];

endmodule
